// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/ack, pop data, memory and status signals of the stack controller
interface stack_ctrl_if #(
    parameter int DEPTH = 15,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = $clog2(DEPTH + 1)
);
    logic [3:0]    push_req;
    logic [43:0]   push_data;
    logic [3:0]    push_ack;
    logic [3:0]    pop_req;
    logic [3:0]    pop_ack;
    logic [10:0]   pop_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [10:0]   mem_wdata;
    logic [10:0]   mem_rdata;
    logic [DW-1:0] depth;
    logic          empty;
    logic          full;
    modport master (
        output push_req, push_data, pop_req, mem_rdata,
        input  push_ack, pop_ack, pop_data, mem_we, mem_addr, mem_wdata, depth, empty, full
    );
    modport slave (
        input  push_req, push_data, pop_req, mem_rdata,
        output push_ack, pop_ack, pop_data, mem_we, mem_addr, mem_wdata, depth, empty, full
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: round-robin push/pop arbiter owning the stack pointer of an external register-file stack
module stack_ctrl #(
    parameter int DEPTH = 15,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input logic        clk,
    input logic        rst,
    stack_ctrl_if.slave bus
);
    logic [DW-1:0] sp_q, sp_d;
    logic [2:0]    rr_q, rr_d, gnt, idx;
    logic [7:0]    last_q, last_d, elig;
    logic [3:0]    push_ack_q, push_ack_d, pop_ack_q, pop_ack_d;
    logic [10:0]   pop_data_q, pop_data_d;
    logic          gnt_v, is_push, is_pop, empty, full;
    logic [1:0]    port;

    assign empty = sp_q == '0;
    assign full  = sp_q == DW'(DEPTH);
    // last_q masks the slot whose requester is still seeing its ack this cycle
    assign elig  = {bus.pop_req & {4{!empty}}, bus.push_req & {4{!full}}} & ~last_q;

    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = rr_q + 3'(k);
            if (elig[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign is_push = gnt_v && !gnt[2];
    assign is_pop  = gnt_v && gnt[2];
    assign port    = gnt[1:0];

    assign bus.mem_we    = is_push && rst;
    assign bus.mem_addr  = is_push ? AW'(sp_q) : is_pop ? AW'(sp_q - 1'b1) : '0;
    assign bus.mem_wdata = is_push ? bus.push_data[11*port +: 11] : '0;

    always_comb begin
        sp_d       = sp_q + DW'(is_push) - DW'(is_pop);
        rr_d       = gnt_v ? gnt + 3'd1 : rr_q;
        push_ack_d = is_push ? 4'b1 << port : 4'b0;
        pop_ack_d  = is_pop ? 4'b1 << port : 4'b0;
        pop_data_d = is_pop ? bus.mem_rdata : pop_data_q;
        last_d     = gnt_v ? 8'b1 << gnt : 8'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q       <= '0;
            rr_q       <= '0;
            push_ack_q <= '0;
            pop_ack_q  <= '0;
            pop_data_q <= '0;
            last_q     <= '0;
        end else begin
            sp_q       <= sp_d;
            rr_q       <= rr_d;
            push_ack_q <= push_ack_d;
            pop_ack_q  <= pop_ack_d;
            pop_data_q <= pop_data_d;
            last_q     <= last_d;
        end
    end

    assign bus.push_ack = push_ack_q;
    assign bus.pop_ack  = pop_ack_q;
    assign bus.pop_data = pop_data_q;
    assign bus.depth    = sp_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed and random checks of stack_ctrl against a queue-based stack model
module tb_stack_ctrl;
    localparam int DEPTH = 15;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_ctrl_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
    stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [10:0] mem [2**AW];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    logic [10:0] q[$];
    int rr_m, last_m, g_log, checks, errors, n;
    logic [10:0] pd_m, v;
    bit drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the grant from the stack rules, check memory strobes, then acks and status.
    task automatic step();
        logic [7:0] req;
        logic [3:0] pa, qa;
        logic [10:0] wd;
        int g, s;
        bit ok;
        #1;
        req = {bus.pop_req, bus.push_req};
        g = -1;
        wd = '0;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                s = (rr_m + k) % 8;
                ok = s < 4 ? q.size() < DEPTH : q.size() > 0;
                if (g < 0 && req[s] && s != last_m && ok) g = s;
            end
        end
        chk("mem_we", bus.mem_we, (g >= 0 && g < 4));
        if (rst) chk("mem_addr", bus.mem_addr, g < 0 ? 0 : (g < 4 ? q.size() : q.size() - 1));
        if (g >= 0 && g < 4) wd = bus.push_data[11*g +: 11];
        if (rst && g < 4) chk("mem_wdata", bus.mem_wdata, wd);
        @(posedge clk);
        pa = '0;
        qa = '0;
        if (!rst) begin
            q.delete();
            rr_m = 0;
            last_m = -1;
            pd_m = '0;
        end else begin
            last_m = g;
            if (g >= 0) rr_m = (g + 1) % 8;
            if (g >= 0 && g < 4) begin
                q.push_back(wd);
                pa[g] = 1'b1;
            end
            if (g >= 4) begin
                pd_m = q.pop_back();
                qa[g-4] = 1'b1;
            end
        end
        g_log = g;
        #1;
        chk("push_ack", bus.push_ack, pa);
        chk("pop_ack", bus.pop_ack, qa);
        chk("pop_data", bus.pop_data, pd_m);
        chk("depth", bus.depth, q.size());
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == DEPTH);
        if (drop) begin
            bus.push_req = bus.push_req & ~bus.push_ack;
            bus.pop_req  = bus.pop_req & ~bus.pop_ack;
        end
    endtask

    task automatic do_push(input int p, input logic [10:0] val, output int cnt);
        bus.push_data[11*p +: 11] = val;
        bus.push_req[p] = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (g_log != p && cnt < 20);
        chk("push_done", g_log, p);
    endtask

    task automatic do_pop(input int p, output logic [10:0] val, output int cnt);
        bus.pop_req[p] = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (g_log != p + 4 && cnt < 20);
        chk("pop_done", g_log, p + 4);
        val = bus.pop_data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rr_m = 0;
        last_m = -1;
        pd_m = '0;
        drop = 1'b1;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        bus.push_req = 4'hf;
        bus.pop_req = 4'hf;
        for (int i = 0; i < 4; i++) bus.push_data[11*i +: 11] = 11'(i + 1);
        // reset with everything requesting
        rst = 1'b0;
        repeat (2) begin
            step();
            chk("rst_empty", bus.empty, 1);
        end
        bus.pop_req = '0;
        rst = 1'b1;
        // fairness: all pushes held on an empty stack
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_order", g_log, i);
        end
        step();
        chk("fair_idle", g_log, -1);
        for (int i = 4; i >= 1; i--) begin
            do_pop(0, v, n);
            chk("fair_pop_val", v, i);
        end
        // LIFO ordering and back-to-back spacing on one port
        do_push(1, 11'd5, n);
        chk("lifo_lat1", n, 1);
        do_push(1, 11'd999, n);
        chk("lifo_lat2", n, 2);
        do_push(1, 11'h400, n);
        chk("lifo_lat3", n, 2);
        do_pop(3, v, n);
        chk("lifo_pop1", v, 11'h400);
        do_pop(3, v, n);
        chk("lifo_pop2", v, 999);
        do_pop(3, v, n);
        chk("lifo_pop3", v, 5);
        chk("lifo_depth", bus.depth, 0);
        // full: 16th push stalls until a pop frees a slot
        for (int i = 0; i < DEPTH; i++) do_push(i % 4, 11'($urandom), n);
        chk("full_flag", bus.full, 1);
        bus.push_data[10:0] = 11'h7ff;
        bus.push_req[0] = 1'b1;
        repeat (3) begin
            step();
            chk("full_stall", g_log, -1);
        end
        bus.pop_req[2] = 1'b1;
        step();
        chk("full_pop", g_log, 6);
        step();
        chk("full_push_resume", g_log, 0);
        for (int i = 0; i < DEPTH; i++) do_pop(i % 4, v, n);
        chk("drained", bus.empty, 1);
        // pops on an empty stack never complete
        bus.pop_req[1] = 1'b1;
        repeat (8) begin
            step();
            chk("empty_stall", g_log, -1);
        end
        bus.pop_req = '0;
        // mixed push/pop contention with requests held continuously
        do_push(0, 11'd100, n);
        do_push(1, 11'd200, n);
        drop = 1'b0;
        bus.push_data[10:0] = 11'd300;
        bus.push_req[0] = 1'b1;
        bus.pop_req[2] = 1'b1;
        repeat (12) step();
        bus.push_req = '0;
        bus.pop_req = '0;
        drop = 1'b1;
        step();
        chk("mixed_nonempty", bus.empty, 0);
        // reset arriving in a pop's grant cycle
        bus.pop_req[3] = 1'b1;
        rst = 1'b0;
        step();
        chk("rst_pop_ack", bus.pop_ack, 0);
        chk("rst_pop_data", bus.pop_data, 0);
        chk("rst_depth", bus.depth, 0);
        bus.pop_req = '0;
        rst = 1'b1;
        step();
        // random traffic with occasional resets
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.push_req[i] && $urandom_range(0, 2) == 0) begin
                    bus.push_data[11*i +: 11] = 11'($urandom);
                    bus.push_req[i] = 1'b1;
                end
                if (!bus.pop_req[i] && $urandom_range(0, 2) == 0) bus.pop_req[i] = 1'b1;
            end
            rst = ($urandom_range(0, 59) != 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
